// File: rtl/rv32i_types.sv
// Shared RV32I out-of-order types: CDB payload, branch tags, and the
// fixed requester numbering on the common data bus.
package rv32i_types;

    localparam int rob_idx_bits = 3;
    localparam int NUM_CDB_REQ  = 5;

    typedef logic [2:0] branch_tag_t;

    typedef enum logic [2:0] {
        alu = 3'd0,
        mul = 3'd1,
        div = 3'd2,
        cmp = 3'd3,
        ld  = 3'd4
    } cdb_req_idx_t;

    typedef struct packed {
        logic                    commit_valid;
        logic [rob_idx_bits-1:0] dest_ROB;
        logic [31:0]             rd_v;
        branch_tag_t             branch_tag;
    } CDB_output_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans from ptr_i upward with wrap and
// returns a one-hot grant for the first set request.
module rr_priority_picker #(
    parameter int N     = 5,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int off = 0; off < N; off++) begin
            // One extra bit so ptr+off cannot overflow before the wrap.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units with a
// single registered broadcast stage; flush and reset suppress grants.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ = 5,
    parameter int ROB_W   = rob_idx_bits
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  CDB_output_t [NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      flush,
    output logic                      cdb_valid,
    output CDB_output_t               cdb_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The payload width is fixed by the shared struct.
    if (ROB_W != rob_idx_bits) begin : g_rob_w_check
        $error("cdb_arbiter: ROB_W must equal rob_idx_bits");
    end

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               cdb_valid_q;
    CDB_output_t        cdb_out_q, cdb_out_d;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic               grant;
    logic [PTR_W-1:0]   gidx;
    CDB_output_t        sel_data;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    assign grant     = gnt_valid && !rst && !flush;
    assign req_ready = grant ? gnt : '0;

    always_comb begin
        gidx     = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx     = PTR_W'(i);
                sel_data = req_data[i];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        cdb_out_d = '0;
        if (grant) begin
            ptr_d                  = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
            cdb_out_d              = sel_data;
            cdb_out_d.commit_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= grant;
            cdb_out_q   <= cdb_out_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_out   = cdb_out_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grant, round-robin order,
// pointer wrap, flush suppression and reset-over-grant.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [4:0]          req_valid;
    CDB_output_t [4:0]   req_data;
    logic [4:0]          req_ready;
    logic                flush;
    logic                cdb_valid;
    CDB_output_t         cdb_out;

    int total = 0;
    int fails = 0;

    cdb_arbiter #(.NUM_REQ(5), .ROB_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_out   (cdb_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bcast(input string tag, input logic [2:0] rob, input logic [31:0] rd);
        chk({tag, "_v"},   64'(cdb_valid), 64'd1);
        chk({tag, "_cv"},  64'(cdb_out.commit_valid), 64'd1);
        chk({tag, "_rob"}, 64'(cdb_out.dest_ROB), 64'(rob));
        chk({tag, "_rd"},  64'(cdb_out.rd_v), 64'(rd));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_v"},   64'(cdb_valid), 64'd0);
        chk({tag, "_out"}, 64'(cdb_out), 64'd0);
    endtask

    function automatic CDB_output_t pl(input logic [2:0] rob, input logic [31:0] rd,
                                       input logic [2:0] tag);
        CDB_output_t p;
        p.commit_valid = 1'b0;
        p.dest_ROB     = rob;
        p.rd_v         = rd;
        p.branch_tag   = tag;
        return p;
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 5'b11111;
        for (int i = 0; i < 5; i++) req_data[i] = pl(3'(i), 32'h1000 + 32'(i), 3'(i));

        // Reset held two cycles with everything requesting.
        @(negedge clk); #1;
        chk("rst_rdy0", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        chk("rst_rdy1", 64'(req_ready), 64'd0);
        chk_idle("rst_cdb");
        rst       = 1'b0;
        req_valid = 5'b00000;

        // Idle cycle.
        @(negedge clk);
        chk_idle("idle");

        // Single requester 2.
        req_data[2] = pl(3'd3, 32'hDEADBEEF, 3'd5);
        req_valid   = 5'b00100;
        #1 chk("one_rdy", 64'(req_ready), 64'b00100);
        @(negedge clk);
        chk_bcast("one_b", 3'd3, 32'hDEADBEEF);
        chk("one_tag", 64'(cdb_out.branch_tag), 64'd5);
        req_valid = 5'b00000;
        @(negedge clk);
        chk_idle("one_after");

        // ptr=3: grant 3 moves ptr to 4, then 4 wins over 1, then 1.
        req_data[2] = pl(3'd2, 32'h1002, 3'd2);
        req_valid   = 5'b01000;
        #1 chk("g3_rdy", 64'(req_ready), 64'b01000);
        @(negedge clk);
        chk_bcast("g3_b", 3'd3, 32'h1003);
        req_valid = 5'b10010;
        #1 chk("wrap_rdy4", 64'(req_ready), 64'b10000);
        @(negedge clk);
        chk_bcast("wrap_b4", 3'd4, 32'h1004);
        req_valid = 5'b00010;
        #1 chk("wrap_rdy1", 64'(req_ready), 64'b00010);

        // Reset over a grant-eligible cycle; ptr is 2 at this point.
        @(negedge clk);
        chk_bcast("wrap_b1", 3'd1, 32'h1001);
        rst       = 1'b1;
        req_valid = 5'b11111;
        #1 chk("rstg_rdy", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk_idle("rstg_cdb");
        rst = 1'b0;

        // All five held valid from ptr=0: 0,1,2,3,4,0 with no bubble.
        for (int k = 0; k < 6; k++) begin
            if (k != 0) begin
                @(negedge clk);
                chk_bcast($sformatf("rr_b%0d", k-1), 3'((k-1) % 5), 32'h1000 + 32'((k-1) % 5));
            end
            #1 chk($sformatf("rr_rdy%0d", k), 64'(req_ready), 64'(5'b00001 << (k % 5)));
        end

        // Flush two cycles with req 0 pending; ptr stays at 1.
        @(negedge clk);
        chk_bcast("rr_b5", 3'd0, 32'h1000);
        flush     = 1'b1;
        req_valid = 5'b00001;
        #1 chk("fl_rdy0", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk_idle("fl_cdb0");
        #1 chk("fl_rdy1", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk_idle("fl_cdb1");
        flush = 1'b0;
        #1 chk("fl_post_rdy", 64'(req_ready), 64'b00001);
        @(negedge clk);
        chk_bcast("fl_post_b", 3'd0, 32'h1000);
        // Grant to 0 puts ptr at 1, so 1 wins over 0.
        req_valid = 5'b00011;
        #1 chk("ptr1_rdy", 64'(req_ready), 64'b00010);
        @(negedge clk);
        chk_bcast("ptr1_b", 3'd1, 32'h1001);
        req_valid = 5'b00000;
        @(negedge clk);
        chk_idle("end_idle");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
